multicyc_mem_resp: RTL

- Memory responder on the far end of the multicycle controller's memory interface; serves both fetch and load/store accesses.
- Samples `mem_rd`/`mem_wr` plus the selected address and store data, inserts a configurable number of wait states, then completes the access with a one-cycle `mem_ready` pulse.
- Holds a word-addressed internal RAM and flags misaligned or out-of-range accesses.
- Lets the controller FSM be exercised against non-zero memory latency.

---
 rtl/multicyc_mem_resp_if.sv | 25 ++
 rtl/multicyc_mem_resp.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/multicyc_mem_resp_if.sv
// Memory bus between the multicycle controller (master) and the memory responder (slave).
// Defining MEMRESP_BYTE_EN adds a 4-bit write lane mask, byte_en.
interface multicyc_mem_resp_if;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        mem_ready;
   logic        mem_err;
   logic        busy;
`ifdef MEMRESP_BYTE_EN
   logic [3:0]  byte_en;

   modport master (output mem_rd, mem_wr, addr, wdata, byte_en,
                   input  rdata, mem_ready, mem_err, busy);
   modport slave  (input  mem_rd, mem_wr, addr, wdata, byte_en,
                   output rdata, mem_ready, mem_err, busy);
`else
   modport master (output mem_rd, mem_wr, addr, wdata,
                   input  rdata, mem_ready, mem_err, busy);
   modport slave  (input  mem_rd, mem_wr, addr, wdata,
                   output rdata, mem_ready, mem_err, busy);
`endif
endinterface

// File: rtl/multicyc_mem_resp.sv
// Word-addressed memory responder with WAIT_CYCLES wait states and a one-cycle ready/err pulse.
// Optional macro MEMRESP_BYTE_EN enables per-lane write masking via bus.byte_en.
module multicyc_mem_resp #(
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 1
) (
   input logic                clk,
   input logic                reset_n,
   multicyc_mem_resp_if.slave bus
);
   localparam int          AW        = $clog2(DEPTH);
   localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
   localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state, state_nxt;
   logic [3:0]    wait_cnt;
   logic [31:0]   lat_addr, lat_wdata;
   logic          lat_rd, lat_wr, lat_err;
`ifdef MEMRESP_BYTE_EN
   logic [3:0]    lat_be;
`endif
   logic [31:0]   rdata_q;
   logic [31:0]   ram [DEPTH];

   logic          capture, enter_resp, ready, err, busy;
   logic [31:0]   req_addr;
   logic          req_rd, req_wr, req_err, ram_we;
   logic [AW-1:0] req_idx, ram_idx;

   // In IDLE the live bus is the request being captured; afterwards the latched copy is.
   assign req_addr = (state == IDLE) ? bus.addr   : lat_addr;
   assign req_rd   = (state == IDLE) ? bus.mem_rd : lat_rd;
   assign req_wr   = (state == IDLE) ? bus.mem_wr : lat_wr;
   assign req_idx  = req_addr[AW+1:2];
   assign ram_idx  = lat_addr[AW+1:2];

   // Range check uses the full address so high bits can never alias into the RAM.
   assign req_err  = (|req_addr[1:0]) || ({2'b00, req_addr[31:2]} >= DEPTH_W) ||
                     (req_rd && req_wr);

   assign ram_we   = (state == RESP) && lat_wr && !lat_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      capture    = 1'b0;
      enter_resp = 1'b0;
      ready      = 1'b0;
      err        = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (bus.mem_rd || bus.mem_wr) begin
               capture = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_nxt  = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nxt = WAIT;
               end
            end
         end
         WAIT: begin
            if (wait_cnt == 4'd0) begin
               state_nxt  = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP: begin
            ready     = 1'b1;
            err       = lat_err;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            busy      = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt  <= 4'd0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_rd    <= 1'b0;
         lat_wr    <= 1'b0;
         lat_err   <= 1'b0;
`ifdef MEMRESP_BYTE_EN
         lat_be    <= 4'd0;
`endif
      end else if (capture) begin
         wait_cnt  <= WAIT_LOAD;
         lat_addr  <= bus.addr;
         lat_wdata <= bus.wdata;
         lat_rd    <= bus.mem_rd;
         lat_wr    <= bus.mem_wr;
         lat_err   <= req_err;
`ifdef MEMRESP_BYTE_EN
         lat_be    <= bus.byte_en;
`endif
      end else if (state == WAIT && wait_cnt != 4'd0) begin
         wait_cnt <= wait_cnt - 4'd1;
      end
   end

   // Read data is loaded on the edge entering RESP so it is already valid with mem_ready.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q <= '0;
      end else if (enter_resp && req_rd && !req_err) begin
         rdata_q <= ram[req_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
`ifdef MEMRESP_BYTE_EN
         for (int i = 0; i < 4; i++) begin
            if (lat_be[i]) begin
               ram[ram_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
            end
         end
`else
         ram[ram_idx] <= lat_wdata;
`endif
      end
   end

   assign bus.rdata     = rdata_q;
   assign bus.mem_ready = ready;
   assign bus.mem_err   = err;
   assign bus.busy      = busy;
endmodule
